i2c_target_mem: RTL and testbench
=================================

# i2c_target_mem

I2C target (slave) that answers at a fixed 7-bit device address and exposes an 8-bit-addressed byte memory port to local logic, with 24Cxx-EEPROM-style register-pointer semantics. It is the far end of the I2C master host interface. On-board it serves as a loop-back target for programmer self-test and as a scratch EEPROM model. It samples SCL/SDA on `clk` and only ever pulls SDA low. It never drives or stretches SCL.

## Interface
- `DEV_ADDR`, 7'h50: 7-bit target address matched against the first byte after START/Sr.
- `FILTER_LEN`, 3: consecutive identical synchronized samples (1..15) required to accept a new SCL or SDA level.
- `clk` in 1: single clock. All logic on posedge.
- `reset` in 1: synchronous, active-high.
- `i2c_scl` in 1: bus clock, input only.
- `i2c_sda` inout 1: bus data, open drain. The block drives 1'b0 or 1'bz, never 1.
- `mem_addr` out 8: current pointer, valid during `mem_wren` and `mem_rden`.
- `mem_wdata` out 8: write byte, valid during `mem_wren`.
- `mem_wren` out 1: one-cycle write strobe.
- `mem_rden` out 1: one-cycle read strobe.
- `mem_rdata` in 8: read data, sampled exactly 1 clk after `mem_rden`.
- `busy` out 1: high from START detection to STOP detection.
- `sel` out 1: high while a transaction addressed to `DEV_ADDR` is active.

## Operation
- **Input path:** 2-FF synchronizer on each pin, then a glitch filter. Filtered levels are `scl_f` and `sda_f`; their edges are detected one clk after the filter updates.
- **START:** `sda_f` falls while `scl_f` is high. Sets `busy`, clears `sel`, releases SDA, enters ADDR with bit count 0. Accepted in every state, so repeated START is supported.
- **STOP:** `sda_f` rises while `scl_f` is high. Clears `busy` and `sel`, releases SDA, enters IDLE. Accepted in every state.
- **Bit timing:** data bits are sampled on `scl_f` rising. SDA drive changes only on `scl_f` falling.
- **State machine** (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE):
  - **ADDR:** shift 8 bits MSB first. After the 8th bit, if bits[7:1] == `DEV_ADDR`, set `sel` and go to ADDR_ACK. Otherwise go to IGNORE and send no ACK. General call (0x00) is not recognised.
  - **ADDR_ACK:** drive SDA low from the next SCL fall to the following SCL fall.
    - If R/W = 0: go to WR_BYTE with a first-byte flag set.
    - If R/W = 1: the `mem_rden` for the first byte was already issued in the cycle the 8th address bit was sampled. `mem_rdata` is loaded into the tx shifter 1 clk later. MSB is driven from the SCL fall that ends the ACK.
  - **WR_BYTE:** shift in 8 bits.
    - If the first-byte flag is set, the byte loads the pointer and no strobe is issued.
    - Otherwise pulse `mem_wren` with `mem_addr` = pointer and `mem_wdata` = byte in the cycle the 8th bit is sampled. The pointer increments in the next cycle.
    - Always go to WR_ACK, which ACKs like ADDR_ACK and then returns to WR_BYTE.
  - **RD_BYTE:**
    - Drive SDA low for each '0' bit and release it for each '1' bit, changing on SCL falls.
    - After the 8th bit's SCL fall, release SDA and go to RD_ACK.
    - The pointer increments 1 clk after each `mem_rden`.
  - **RD_ACK:** sample SDA on SCL rise.
    - If 0 (master ACK): pulse `mem_rden` in that cycle, load the shifter 1 clk later, go to RD_BYTE.
    - If 1 (NACK): go to IGNORE with no further strobe.
  - **IGNORE:** SDA released. Waits for START or STOP.
- **Pointer:** 8 bits, wraps 0xFF→0x00. Cleared only by `reset`. Persists across STOP, so current-address reads are supported.
- **Boundary cases:**
  - START or STOP mid-byte discards the partial byte and issues no strobe.
  - A write then Sr then read (combined format) reads from the pointer just set.

## Timing
- **Reset:** SDA hi-Z, all outputs 0, pointer 0x00, state IDLE, filter outputs 1. Reset asserted mid-transaction releases SDA at the first clk edge where reset is sampled.
- **Pin-to-edge latency:** 2 (sync) + `FILTER_LEN` + 1 clk.
- **SDA response latency:** SDA drive changes within 1 clk of a detected SCL fall.
- **Clock ratio:** the `clk` period must be ≤ 1/16 of the SCL low time, so SDA setup and mem read turnaround fit inside SCL low.
- **Strobes:** `mem_wren` and `mem_rden` are exactly 1 clk wide and never asserted in the same cycle. `mem_rdata` has fixed 1-clk latency.
- **Pulse rejection:** a pulse shorter than `FILTER_LEN` clk on either pin is ignored entirely.

## Test plan
- **Write:** START, 0xA0, 0x10, 0xA5, 0x5A, STOP -> ACK on all 4 ninth clocks; `mem_wren` at (0x10,0xA5) then (0x11,0x5A); pointer ends at 0x12; `busy` and `sel` low after STOP.
- **Combined read:** START 0xA0 0x20, Sr 0xA1, 3 bytes with master ACK, ACK, NACK, memory model returning ~addr -> SDA bytes 0xDF, 0xDE, 0xDD; exactly 3 `mem_rden` at 0x20, 0x21, 0x22; SDA released after 3rd byte.
- **Address mismatch:** START 0xA2 then 2 bytes -> SDA never driven; no strobes; `sel` = 0; `busy` = 1 until STOP.
- **Pointer wrap:** pointer byte 0xFF, data 0x11, 0x22 -> writes at 0xFF then 0x00; then START 0xA1 with 1 byte + NACK -> reads address 0x01.
- **Glitch rejection:** SDA low for `FILTER_LEN`-1 clk while SCL high in IDLE -> `busy` stays 0. For `FILTER_LEN`+1 clk -> `busy` rises.
- **Reset mid-operation:** reset asserted while driving a '0' read bit -> SDA hi-Z next clk; `busy` = 0, `sel` = 0, pointer 0x00. A following write transaction works normally.

Source files
------------

// File: rtl/i2c_target_mem.sv
// i2c_target_mem
// I2C target answering at a fixed 7-bit address. It exposes an 8-bit-addressed
// byte memory port to local logic and uses 24Cxx-EEPROM-style pointer
// semantics. The first written byte sets the pointer, and every data byte
// after that advances it. Reads start at the current pointer. SCL and SDA are
// oversampled on clk. SDA is only ever pulled low, and SCL is never driven.
//
// Ports
//   clk        system clock; every register updates on its rising edge
//   reset      synchronous, active-high
//   i2c_scl    bus clock (input only)
//   i2c_sda    bus data, open drain (this block drives 0 or z)
//   mem_addr   current pointer, valid while mem_wren / mem_rden are high
//   mem_wdata  write byte, valid while mem_wren is high
//   mem_wren   one-cycle write strobe
//   mem_rden   one-cycle read strobe
//   mem_rdata  read data, sampled exactly one clk after mem_rden
//   busy       high from START detection to STOP detection
//   sel        high while a transaction addressed to DEV_ADDR is active
module i2c_target_mem #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_wren,
    output logic       mem_rden,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       sel
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input path: index 1 = SCL, index 0 = SDA
    // ------------------------------------------------------------------
    logic [1:0] sync1, sync2, filt, filt_q;
    logic [3:0] cnt [2];

    // A new level is accepted once FILTER_LEN consecutive synchronized
    // samples disagree with the current filtered level. Any agreeing sample
    // restarts the count, so a shorter pulse leaves no trace.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values, independent of statement order.
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_q <= '1;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1  <= {i2c_scl, i2c_sda};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det;

    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_rise  =  filt[1] & ~filt_q[1];
    assign scl_fall  = ~filt[1] &  filt_q[1];
    assign sda_rise  =  filt[0] & ~filt_q[0];
    assign sda_fall  = ~filt[0] &  filt_q[0];
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    // ------------------------------------------------------------------
    // Protocol state machine
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;   // bit index; in ACK states, the phase
    logic [7:0] rx, rx_n, rx_byte;
    logic [7:0] tx, tx_n;
    logic [7:0] ptr, ptr_n;
    logic       first_byte, first_n;
    logic       rw, rw_n;
    logic       sda_low, sda_low_n;
    logic       sel_n, busy_n, wren_n, rden_n;
    logic [7:0] wdata_n;
    logic       load_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx           <= '0;
            tx           <= '0;
            ptr          <= '0;
            first_byte   <= 1'b0;
            rw           <= 1'b0;
            sda_low      <= 1'b0;
            sel          <= 1'b0;
            busy         <= 1'b0;
            mem_wren     <= 1'b0;
            mem_rden     <= 1'b0;
            mem_wdata    <= '0;
            load_pending <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            rx           <= rx_n;
            tx           <= tx_n;
            ptr          <= ptr_n;
            first_byte   <= first_n;
            rw           <= rw_n;
            sda_low      <= sda_low_n;
            sel          <= sel_n;
            busy         <= busy_n;
            mem_wren     <= wren_n;
            mem_rden     <= rden_n;
            mem_wdata    <= wdata_n;
            load_pending <= mem_rden;   // read data is valid one clk after the strobe
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        rx_n      = rx;
        tx_n      = tx;
        ptr_n     = ptr;
        first_n   = first_byte;
        rw_n      = rw;
        sda_low_n = sda_low;
        sel_n     = sel;
        busy_n    = busy;
        wren_n    = 1'b0;
        rden_n    = 1'b0;
        wdata_n   = mem_wdata;
        rx_byte   = {rx[6:0], sda_f};

        if (load_pending) tx_n = mem_rdata;
        // The pointer advances in the cycle after each strobe. That keeps
        // mem_addr stable for the whole strobe cycle.
        if (mem_wren || mem_rden) ptr_n = ptr + 8'd1;

        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            busy_n    = 1'b0;
            sel_n     = 1'b0;
            sda_low_n = 1'b0;
        end else if (start_det) begin
            // A START mid-byte lands here too. The partial byte is dropped.
            state_n   = ADDR;
            bit_cnt_n = '0;
            busy_n    = 1'b1;
            sel_n     = 1'b0;
            sda_low_n = 1'b0;
            first_n   = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        rx_n      = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n = '0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                sel_n   = 1'b1;
                                rw_n    = rx_byte[0];
                                state_n = ADDR_ACK;
                                // Fetch the first read byte now. It then
                                // sits in tx long before the ACK ends.
                                rden_n  = rx_byte[0];
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end

                // Phase 0 waits for the SCL fall that starts the ACK slot.
                // Phase 1 waits for the fall that ends it.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_low_n = 1'b1;
                            bit_cnt_n = 3'd1;
                        end else begin
                            bit_cnt_n = '0;
                            if (state == ADDR_ACK && rw) begin
                                state_n   = RD_BYTE;
                                sda_low_n = ~tx[7];
                            end else begin
                                state_n   = WR_BYTE;
                                sda_low_n = 1'b0;
                                if (state == ADDR_ACK) first_n = 1'b1;
                            end
                        end
                    end
                end

                WR_BYTE: begin
                    if (scl_rise) begin
                        rx_n      = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n = '0;
                            state_n   = WR_ACK;
                            if (first_byte) begin
                                ptr_n   = rx_byte;
                                first_n = 1'b0;
                            end else begin
                                wren_n  = 1'b1;
                                wdata_n = rx_byte;
                            end
                        end
                    end
                end

                // tx[7] is always the bit on the bus. Each SCL fall shifts
                // the next bit up.
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n = '0;
                            sda_low_n = 1'b0;
                            state_n   = RD_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                            tx_n      = {tx[6:0], 1'b0};
                            sda_low_n = ~tx[6];
                        end
                    end
                end

                // Phase 0 samples the master's ACK/NACK. After an ACK,
                // phase 1 waits for the SCL fall that starts the next byte.
                RD_ACK: begin
                    if (bit_cnt == 3'd0) begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                rden_n    = 1'b1;
                                bit_cnt_n = 3'd1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        bit_cnt_n = '0;
                        state_n   = RD_BYTE;
                        sda_low_n = ~tx[7];
                    end
                end

                default: ;   // IDLE, IGNORE: only START/STOP matter
            endcase
        end
    end

    assign i2c_sda  = sda_low ? 1'b0 : 1'bz;
    assign mem_addr = ptr;

endmodule

// File: tb/tb_i2c_target_mem.sv
`timescale 1ns/1ps
module tb_i2c_target_mem;

    localparam int H = 200;          // SCL half period in ns (20 clk)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;        // master pulls SDA low
    wire        sda_bus;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_wren, mem_rden, busy, sel;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_target_mem #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_scl   (scl),
        .i2c_sda   (sda_bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rden  (mem_rden),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read returning the inverted address.
    always @(posedge clk) if (mem_rden) mem_rdata <= ~mem_addr;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] rd_addr_q[$];
    int         overlap_cnt = 0;
    int         drive_cnt = 0;

    always @(posedge clk) begin
        if (mem_wren) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_rden) rd_addr_q.push_back(mem_addr);
        if (mem_wren && mem_rden) overlap_cnt++;
    end

    // Counts clocks where SDA is low while the master has released it.
    always @(negedge clk) if (!m_low && sda_bus === 1'b0) drive_cnt++;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic align;
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic v, output logic s);
        #(H/2) m_low = ~v;
        #(H/2) scl = 1'b1;
        #(H/2) s = sda_bus;
        #(H/2) scl = 1'b0;
    endtask

    task automatic i2c_start;
        m_low = 1'b0;
        #(H/2) scl = 1'b1;
        #H     m_low = 1'b1;
        #H     scl = 1'b0;
    endtask

    task automatic i2c_stop;
        #(H/2) m_low = 1'b1;
        #(H/2) scl = 1'b1;
        #H     m_low = 1'b0;
        #H;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = (s === 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d, output logic line);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(~master_ack, s);
        line = s;
    endtask

    initial begin
        logic       a0, a1, a2, a3, a4, ln;
        logic [7:0] d0, d1, d2;
        int         wb, rb, db;

        // ---------------- reset state ----------------
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_strobes", 32'({mem_wren, mem_rden}), 32'h0);
        check("rst_ptr", 32'(mem_addr), 32'h00);
        check("rst_sda", 32'(sda_bus), 32'h1);
        @(negedge clk) reset = 1'b0;
        repeat (10) @(negedge clk);

        // ---------------- glitch rejection ----------------
        m_low = 1'b1;
        repeat (2) @(negedge clk);
        m_low = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_short_busy", 32'(busy), 32'h0);
        m_low = 1'b1;
        repeat (4) @(negedge clk);
        m_low = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_long_busy", 32'(busy), 32'h1);
        repeat (20) @(negedge clk);
        check("glitch_stop_busy", 32'(busy), 32'h0);

        // ---------------- write ----------------
        align;
        wb = wr_addr_q.size();
        i2c_start;
        write_byte(8'hA0, a0);
        check("wr_sel", 32'(sel), 32'h1);
        write_byte(8'h10, a1);
        write_byte(8'hA5, a2);
        write_byte(8'h5A, a3);
        check("wr_busy_mid", 32'(busy), 32'h1);
        i2c_stop;
        #H;
        check("wr_acks", 32'({a0, a1, a2, a3}), 32'hF);
        check("wr_count", 32'(wr_addr_q.size() - wb), 32'h2);
        if (wr_addr_q.size() - wb == 2) begin
            check("wr0_addr", 32'(wr_addr_q[wb]), 32'h10);
            check("wr0_data", 32'(wr_data_q[wb]), 32'hA5);
            check("wr1_addr", 32'(wr_addr_q[wb+1]), 32'h11);
            check("wr1_data", 32'(wr_data_q[wb+1]), 32'h5A);
        end
        check("wr_ptr_end", 32'(mem_addr), 32'h12);
        check("wr_busy_end", 32'(busy), 32'h0);
        check("wr_sel_end", 32'(sel), 32'h0);

        // ---------------- combined read ----------------
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        i2c_start;
        write_byte(8'hA0, a0);
        write_byte(8'h20, a1);
        i2c_start;
        write_byte(8'hA1, a2);
        read_byte(1'b1, d0, ln);
        read_byte(1'b1, d1, ln);
        read_byte(1'b0, d2, ln);
        check("rd_nack_released", 32'(ln), 32'h1);
        i2c_stop;
        #H;
        check("rd_acks", 32'({a0, a1, a2}), 32'h7);
        check("rd_byte0", 32'(d0), 32'hDF);
        check("rd_byte1", 32'(d1), 32'hDE);
        check("rd_byte2", 32'(d2), 32'hDD);
        check("rd_count", 32'(rd_addr_q.size() - rb), 32'h3);
        if (rd_addr_q.size() - rb == 3) begin
            check("rd0_addr", 32'(rd_addr_q[rb]), 32'h20);
            check("rd1_addr", 32'(rd_addr_q[rb+1]), 32'h21);
            check("rd2_addr", 32'(rd_addr_q[rb+2]), 32'h22);
        end
        check("rd_no_writes", 32'(wr_addr_q.size() - wb), 32'h0);

        // ---------------- address mismatch ----------------
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        db = drive_cnt;
        i2c_start;
        write_byte(8'hA2, a0);
        write_byte(8'h12, a1);
        write_byte(8'h34, a2);
        check("mm_acks", 32'({a0, a1, a2}), 32'h0);
        check("mm_sel", 32'(sel), 32'h0);
        check("mm_busy_mid", 32'(busy), 32'h1);
        i2c_stop;
        #H;
        check("mm_busy_end", 32'(busy), 32'h0);
        check("mm_sda_drive", 32'(drive_cnt - db), 32'h0);
        check("mm_strobes", 32'((wr_addr_q.size() - wb) + (rd_addr_q.size() - rb)), 32'h0);

        // ---------------- pointer wrap ----------------
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        i2c_start;
        write_byte(8'hA0, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop;
        check("wrap_count", 32'(wr_addr_q.size() - wb), 32'h2);
        if (wr_addr_q.size() - wb == 2) begin
            check("wrap0_addr", 32'(wr_addr_q[wb]), 32'hFF);
            check("wrap0_data", 32'(wr_data_q[wb]), 32'h11);
            check("wrap1_addr", 32'(wr_addr_q[wb+1]), 32'h00);
            check("wrap1_data", 32'(wr_data_q[wb+1]), 32'h22);
        end
        i2c_start;
        write_byte(8'hA1, a4);
        read_byte(1'b0, d0, ln);
        i2c_stop;
        check("wrap_acks", 32'({a0, a1, a2, a3, a4}), 32'h1F);
        check("wrap_rd_data", 32'(d0), 32'hFE);
        check("wrap_rd_count", 32'(rd_addr_q.size() - rb), 32'h1);
        if (rd_addr_q.size() - rb == 1)
            check("wrap_rd_addr", 32'(rd_addr_q[rb]), 32'h01);

        // ---------------- reset mid-operation ----------------
        i2c_start;
        write_byte(8'hA0, a0);
        write_byte(8'h80, a1);
        i2c_start;
        write_byte(8'hA1, a2);
        check("mid_acks", 32'({a0, a1, a2}), 32'h7);
        repeat (15) @(posedge clk);
        #1;
        check("mid_sda_driven_low", 32'(sda_bus), 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_sda", 32'(sda_bus), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_ptr", 32'(mem_addr), 32'h00);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
        align;
        wb = wr_addr_q.size();
        i2c_start;
        write_byte(8'hA0, a0);
        write_byte(8'h05, a1);
        write_byte(8'h33, a2);
        i2c_stop;
        check("post_acks", 32'({a0, a1, a2}), 32'h7);
        check("post_count", 32'(wr_addr_q.size() - wb), 32'h1);
        if (wr_addr_q.size() - wb == 1) begin
            check("post_addr", 32'(wr_addr_q[wb]), 32'h05);
            check("post_data", 32'(wr_data_q[wb]), 32'h33);
        end
        check("post_ptr", 32'(mem_addr), 32'h06);

        check("strobe_overlap", 32'(overlap_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
